// File: rtl/syscall_unit.sv
// syscall_unit: responds to the controller's syscall strobe in the
// single-cycle MIPS datapath. Halts on HALT_CODE, latches $a0 for the
// seven-segment display on PRINT_CODE, counts accepted syscalls and
// cycles in which the PC advanced.
//
// Build option: define SYSCALL_PAUSE_EN to hold the CPU after every
// non-halt syscall until the operator pulses go. Without it the PAUSE
// and RESUME states are unreachable, paused is tied low and go is unused.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal execution, the only state that accepts a syscall
// PAUSE  | PC held, waiting for the operator go pulse
// RESUME | one cycle, PC steps past the syscall, syscall ignored
// HALT   | terminal, PC held until rst

module syscall_unit #(
  parameter int          CNT_W      = 16,
  parameter logic [31:0] HALT_CODE  = 32'd10,
  parameter logic [31:0] PRINT_CODE = 32'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             syscall,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  input  logic             go,
  output logic             pc_stall,
  output logic             halted,
  output logic             paused,
  output logic [31:0]      disp_data,
  output logic             disp_valid,
  output logic [CNT_W-1:0] sys_count,
  output logic [31:0]      cycle_count
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_PAUSE  = 2'd1,
    S_RESUME = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  state_e           state_q;
  logic             halted_q;
  logic             paused_q;
  logic [31:0]      disp_data_q;
  logic             disp_valid_q;
  logic [CNT_W-1:0] sys_cnt_q;
  logic [CNT_W-1:0] sys_cnt_d;
  logic [31:0]      cycle_cnt_q;
  logic [31:0]      cycle_cnt_d;

  logic accept;
  logic is_halt;
  logic is_print;
  logic pause_elig;

  assign accept   = (state_q == S_RUN) & syscall;
  assign is_halt  = (v0 == HALT_CODE);
  assign is_print = (v0 == PRINT_CODE);

`ifdef SYSCALL_PAUSE_EN
  assign pause_elig = ~is_halt;
`else
  logic unused_go;
  assign pause_elig = 1'b0;
  assign unused_go  = go;
`endif

  // Zero-latency stall so a halting or pausing syscall keeps the PC on itself
  assign pc_stall = (state_q == S_PAUSE) | (state_q == S_HALT) |
                    (accept & (is_halt | pause_elig));

  // Next values of the two counters: saturating syscall count, wrapping cycle count
  always_comb begin
    sys_cnt_d   = sys_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    if (accept && (sys_cnt_q != {CNT_W{1'b1}}))
      sys_cnt_d = sys_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (!pc_stall)
      cycle_cnt_d = cycle_cnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sys_cnt_q   <= '0;
      cycle_cnt_q <= '0;
    end else begin
      sys_cnt_q   <= sys_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Syscall FSM with registered status and display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      halted_q     <= 1'b0;
      paused_q     <= 1'b0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      disp_valid_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (syscall) begin
            if (is_halt) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              if (is_print) begin
                disp_data_q  <= a0;
                disp_valid_q <= 1'b1;
              end
`ifdef SYSCALL_PAUSE_EN
              state_q  <= S_PAUSE;
              paused_q <= 1'b1;
`endif
            end
          end
        end
`ifdef SYSCALL_PAUSE_EN
        S_PAUSE: begin
          if (go) begin
            state_q  <= S_RESUME;
            paused_q <= 1'b0;
          end
        end
        // syscall is still high for the stalled instruction; ignore it here
        S_RESUME: state_q <= S_RUN;
`endif
        S_HALT: state_q <= S_HALT;
        default: begin
          state_q  <= S_RUN;
          paused_q <= 1'b0;
        end
      endcase
    end
  end

  assign halted      = halted_q;
  assign paused      = paused_q;
  assign disp_data   = disp_data_q;
  assign disp_valid  = disp_valid_q;
  assign sys_count   = sys_cnt_q;
  assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit (CNT_W=4 so saturation is quick to reach).
// Works with or without SYSCALL_PAUSE_EN defined.
module tb_syscall_unit;

`ifdef SYSCALL_PAUSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        syscall = 1'b0;
  logic [31:0] v0 = 32'd0;
  logic [31:0] a0 = 32'd0;
  logic        go = 1'b0;
  logic        pc_stall, halted, paused, disp_valid;
  logic [31:0] disp_data, cycle_count;
  logic [3:0]  sys_count;

  int n_cmp = 0;
  int n_err = 0;

  syscall_unit #(.CNT_W(4), .HALT_CODE(32'd10), .PRINT_CODE(32'd1)) dut (
    .clk(clk), .rst(rst), .syscall(syscall), .v0(v0), .a0(a0), .go(go),
    .pc_stall(pc_stall), .halted(halted), .paused(paused),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .sys_count(sys_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Reference model: "is the CPU halted / waiting / just released", plus counters
  bit          m_halt, m_wait, m_resume, m_dv;
  logic [31:0] m_dd, m_cyc;
  int          m_sys;

  function automatic bit model_stall();
    bit call_blocks;
    call_blocks = syscall && (v0 == 32'd10 || PEN);
    return m_halt || m_wait || (!m_resume && call_blocks);
  endfunction

  task automatic step();
    bit st, n_halt, n_wait, n_resume, n_dv;
    logic [31:0] n_dd, n_cyc;
    int n_sys;
    st = model_stall();
    n_halt = m_halt; n_wait = m_wait; n_resume = 1'b0; n_dv = 1'b0;
    n_dd = m_dd; n_sys = m_sys; n_cyc = m_cyc;
    if (rst) begin
      n_halt = 0; n_wait = 0; n_dd = 0; n_sys = 0; n_cyc = 0;
    end else begin
      if (!st) n_cyc = m_cyc + 32'd1;
      if (m_halt) begin
      end else if (m_wait) begin
        if (go) begin n_wait = 0; n_resume = 1; end
      end else if (m_resume) begin
      end else if (syscall) begin
        n_sys = (m_sys < 15) ? m_sys + 1 : 15;
        if (v0 == 32'd10) n_halt = 1;
        else begin
          if (v0 == 32'd1) begin n_dd = a0; n_dv = 1; end
          if (PEN) n_wait = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    m_halt = n_halt; m_wait = n_wait; m_resume = n_resume; m_dv = n_dv;
    m_dd = n_dd; m_sys = n_sys; m_cyc = n_cyc;
  endtask

  task automatic test_reset();
    rst = 1; syscall = 0; go = 0; v0 = 0; a0 = 0;
    step(); step();
    rst = 0; #1;
    n_cmp++; if (pc_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", pc_stall); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b expected 0", halted); end
    n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL reset_paused: got %b expected 0", paused); end
    n_cmp++; if (disp_data !== 32'd0) begin n_err++; $display("FAIL reset_disp: got %h expected 0", disp_data); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %b expected 0", disp_valid); end
    n_cmp++; if (sys_count !== 4'd0) begin n_err++; $display("FAIL reset_sys: got %0d expected 0", sys_count); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL reset_cyc: got %0d expected 0", cycle_count); end
    repeat (5) step();
    n_cmp++; if (cycle_count !== 32'd5) begin n_err++; $display("FAIL free_run_cyc: got %0d expected 5", cycle_count); end
  endtask

  task automatic test_print();
    logic [31:0] frozen;
    syscall = 1; v0 = 32'd1; a0 = 32'h0000_00AB; #1;
    n_cmp++; if (pc_stall !== PEN) begin n_err++; $display("FAIL print_stall: got %b expected %b", pc_stall, PEN); end
    step();
    if (!PEN) syscall = 0;
    #1;
    n_cmp++; if (disp_data !== 32'hAB) begin n_err++; $display("FAIL print_data: got %h expected ab", disp_data); end
    n_cmp++; if (disp_valid !== 1'b1) begin n_err++; $display("FAIL print_dv: got %b expected 1", disp_valid); end
    n_cmp++; if (paused !== PEN) begin n_err++; $display("FAIL print_paused: got %b expected %b", paused, PEN); end
    n_cmp++; if (sys_count !== 4'd1) begin n_err++; $display("FAIL print_sys: got %0d expected 1", sys_count); end
    n_cmp++; if (cycle_count !== m_cyc) begin n_err++; $display("FAIL print_cyc: got %0d expected %0d", cycle_count, m_cyc); end
    step();
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL print_dv_pulse: got %b expected 0", disp_valid); end
    if (PEN) begin
      frozen = m_cyc;
      repeat (4) step();
      n_cmp++; if (paused !== 1'b1) begin n_err++; $display("FAIL pause_hold: got %b expected 1", paused); end
      n_cmp++; if (cycle_count !== frozen) begin n_err++; $display("FAIL pause_cyc: got %0d expected %0d", cycle_count, frozen); end
      go = 1; #1;
      n_cmp++; if (pc_stall !== 1'b1) begin n_err++; $display("FAIL go_cycle_stall: got %b expected 1", pc_stall); end
      step(); go = 0; #1;
      n_cmp++; if (pc_stall !== 1'b0) begin n_err++; $display("FAIL resume_stall: got %b expected 0", pc_stall); end
      n_cmp++; if (sys_count !== 4'd1) begin n_err++; $display("FAIL resume_sys: got %0d expected 1", sys_count); end
      n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL resume_paused: got %b expected 0", paused); end
      step(); syscall = 0; #1;
      n_cmp++; if (cycle_count !== frozen + 32'd1) begin n_err++; $display("FAIL resume_cyc: got %0d expected %0d", cycle_count, frozen + 32'd1); end
      n_cmp++; if (sys_count !== 4'd1) begin n_err++; $display("FAIL after_resume_sys: got %0d expected 1", sys_count); end
    end
  endtask

  task automatic test_halt();
    logic [31:0] frozen;
    rst = 1; step(); rst = 0;
    syscall = 1; v0 = 32'd10; #1;
    n_cmp++; if (pc_stall !== 1'b1) begin n_err++; $display("FAIL halt_stall: got %b expected 1", pc_stall); end
    step(); syscall = 0; #1;
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_flag: got %b expected 1", halted); end
    n_cmp++; if (pc_stall !== 1'b1) begin n_err++; $display("FAIL halt_stall_hold: got %b expected 1", pc_stall); end
    frozen = m_cyc;
    for (int i = 0; i < 20; i++) begin
      go = (i % 3 == 0); syscall = (i % 5 == 0); v0 = 32'd1;
      step();
    end
    go = 0; syscall = 0; #1;
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_sticky: got %b expected 1", halted); end
    n_cmp++; if (cycle_count !== frozen) begin n_err++; $display("FAIL halt_cyc: got %0d expected %0d", cycle_count, frozen); end
    n_cmp++; if (sys_count !== 4'd1) begin n_err++; $display("FAIL halt_sys: got %0d expected 1", sys_count); end
    rst = 1; step(); rst = 0; #1;
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_rst_halted: got %b expected 0", halted); end
    n_cmp++; if (pc_stall !== 1'b0) begin n_err++; $display("FAIL halt_rst_stall: got %b expected 0", pc_stall); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL halt_rst_cyc: got %0d expected 0", cycle_count); end
    n_cmp++; if (sys_count !== 4'd0) begin n_err++; $display("FAIL halt_rst_sys: got %0d expected 0", sys_count); end
  endtask

  task automatic test_unknown();
    rst = 1; step(); rst = 0;
    syscall = 1; v0 = 32'd5; a0 = $urandom; #1;
    n_cmp++; if (pc_stall !== PEN) begin n_err++; $display("FAIL unk_stall: got %b expected %b", pc_stall, PEN); end
    step(); if (!PEN) syscall = 0;
    #1;
    n_cmp++; if (sys_count !== 4'd1) begin n_err++; $display("FAIL unk_sys: got %0d expected 1", sys_count); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL unk_dv: got %b expected 0", disp_valid); end
    n_cmp++; if (disp_data !== 32'd0) begin n_err++; $display("FAIL unk_data: got %h expected 0", disp_data); end
    n_cmp++; if (cycle_count !== (PEN ? 32'd0 : 32'd1)) begin n_err++; $display("FAIL unk_cyc: got %0d expected %0d", cycle_count, PEN ? 0 : 1); end
    if (PEN) begin go = 1; step(); go = 0; step(); syscall = 0; end
  endtask

  task automatic test_reset_mid_pause();
    rst = 1; step(); rst = 0;
    syscall = 1; v0 = 32'd1; a0 = 32'h55;
    step(); if (!PEN) syscall = 0;
    #1;
    n_cmp++; if (paused !== PEN) begin n_err++; $display("FAIL mid_paused: got %b expected %b", paused, PEN); end
    rst = 1; go = 1; step(); rst = 0; go = 0; syscall = 0; #1;
    n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL mid_rst_paused: got %b expected 0", paused); end
    n_cmp++; if (sys_count !== 4'd0) begin n_err++; $display("FAIL mid_rst_sys: got %0d expected 0", sys_count); end
    n_cmp++; if (disp_data !== 32'd0) begin n_err++; $display("FAIL mid_rst_data: got %h expected 0", disp_data); end
    step();
    n_cmp++; if (cycle_count !== 32'd1) begin n_err++; $display("FAIL mid_rst_cyc: got %0d expected 1", cycle_count); end
    n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL mid_rst_run: got %b expected 0", paused); end
  endtask

  task automatic test_saturation();
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 20; i++) begin
      syscall = 1;
      v0 = (i % 2 == 0) ? 32'd1 : 32'd5;
      a0 = $urandom;
      step();
      if (PEN) begin go = 1; step(); go = 0; step(); end
      syscall = 0;
      step();
      if (i == 13) begin
        n_cmp++; if (sys_count !== 4'd14) begin n_err++; $display("FAIL sat_mid: got %0d expected 14", sys_count); end
      end
    end
    n_cmp++; if (sys_count !== 4'hF) begin n_err++; $display("FAIL sat_final: got %0d expected 15", sys_count); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL sat_halted: got %b expected 0", halted); end
  endtask

  task automatic test_random();
    int r;
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom % 40) == 0;
      syscall = ($urandom % 3) == 0;
      go = ($urandom % 4) == 0;
      a0 = $urandom;
      r = $urandom % 12;
      if (r == 0) v0 = 32'd10;
      else if (r < 5) v0 = 32'd1;
      else v0 = $urandom % 16;
      #1;
      n_cmp++; if (pc_stall !== model_stall()) begin n_err++; $display("FAIL rnd_stall[%0d]: got %b expected %b", i, pc_stall, model_stall()); end
      step();
      n_cmp++; if (halted !== m_halt) begin n_err++; $display("FAIL rnd_halted[%0d]: got %b expected %b", i, halted, m_halt); end
      n_cmp++; if (paused !== m_wait) begin n_err++; $display("FAIL rnd_paused[%0d]: got %b expected %b", i, paused, m_wait); end
      n_cmp++; if (disp_data !== m_dd) begin n_err++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, disp_data, m_dd); end
      n_cmp++; if (disp_valid !== m_dv) begin n_err++; $display("FAIL rnd_dv[%0d]: got %b expected %b", i, disp_valid, m_dv); end
      n_cmp++; if (sys_count !== 4'(m_sys)) begin n_err++; $display("FAIL rnd_sys[%0d]: got %0d expected %0d", i, sys_count, m_sys); end
      n_cmp++; if (cycle_count !== m_cyc) begin n_err++; $display("FAIL rnd_cyc[%0d]: got %0d expected %0d", i, cycle_count, m_cyc); end
    end
    rst = 0; syscall = 0; go = 0;
  endtask

  initial begin
    m_halt = 0; m_wait = 0; m_resume = 0; m_dv = 0;
    m_dd = 0; m_sys = 0; m_cyc = 0;
    test_reset();
    test_print();
    test_halt();
    test_unknown();
    test_reset_mid_pause();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
